parking_gate_controller: RTL and testbench



---
 rtl/parking_gate_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_parking_gate_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_controller
// Description : Lane-side front end for the parking-occupancy counter.
//               Synchronises and debounces the outer/inner beam-break sensors,
//               tracks a car through the lane with a small FSM, and emits
//               single-cycle car_enter / car_exit pulses for the counter.
//               Entry is refused while the lot is full. A watchdog and an
//               illegal-sequence check drive the fault flag.
// Ports       : clk, reset (async, active-high)
//               sensor_outer, sensor_inner : raw beams, 1 = broken, async
//               spots_free                 : free-spot count from counter
//               car_enter, car_exit        : one-cycle event pulses
//               gate_open                  : barrier raise command
//               full_lamp                  : high while spots_free == 0
//               fault                      : timeout / illegal sequence
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_controller #(
    parameter int SPOT_W          = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sensor_outer,
    input  logic              sensor_inner,
    input  logic [SPOT_W-1:0] spots_free,
    output logic              car_enter,
    output logic              car_exit,
    output logic              gate_open,
    output logic              full_lamp,
    output logic              fault
);

    // One shared counter serves the traversal watchdog and the fault-exit
    // hold time, so it is sized for the larger of the two.
    localparam int c_cnt_max = (TIMEOUT_CYCLES > DEBOUNCE_CYCLES) ? TIMEOUT_CYCLES
                                                                  : DEBOUNCE_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_db_w    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_flt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(c_cnt_max);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EN_O  = 3'd1,
        ST_EN_OI = 3'd2,
        ST_EN_I  = 3'd3,
        ST_EX_I  = 3'd4,
        ST_EX_IO = 3'd5,
        ST_EX_O  = 3'd6,
        ST_FAULT = 3'd7
    } state_t;

    // Sensor vectors: bit 1 = outer, bit 0 = inner.
    logic [1:0]        sync1_q, sync2_q;
    logic [1:0]        deb_q, deb_d;
    logic [c_db_w-1:0] db_cnt_q [2];
    logic [c_db_w-1:0] db_cnt_d [2];

    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               car_enter_q, car_enter_d;
    logic               car_exit_q, car_exit_d;
    logic               gate_open_q, gate_open_d;
    logic               full_lamp_q, full_lamp_d;
    logic               fault_q, fault_d;
    logic               in_trav;

    // ------------------------------------------------------------------
    // Debounce: the accepted value follows the synchronised value only
    // after it has disagreed for DEBOUNCE_CYCLES consecutive cycles; any
    // agreement in between restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        deb_d = deb_q;
        for (int s = 0; s < 2; s++) begin
            db_cnt_d[s] = '0;
            if (sync2_q[s] != deb_q[s]) begin
                if (db_cnt_q[s] == c_db_last) begin
                    deb_d[s] = sync2_q[s];
                end else begin
                    db_cnt_d[s] = db_cnt_q[s] + c_db_w'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane FSM: next state, pulses and shared counter
    // ------------------------------------------------------------------
    always_comb begin
        in_trav = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    end

    always_comb begin
        state_d     = state_q;
        car_enter_d = 1'b0;
        car_exit_d  = 1'b0;
        cnt_d       = '0;

        case (state_q)
            ST_IDLE: begin
                case (deb_q)
                    2'b10:   if (spots_free != '0) state_d = ST_EN_O;
                    2'b01:   state_d = ST_EX_I;
                    2'b11:   state_d = ST_FAULT;
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_EN_O: begin
                case (deb_q)
                    2'b11:   state_d = ST_EN_OI;
                    2'b00:   state_d = ST_IDLE;   // backed out, no event
                    2'b01:   state_d = ST_FAULT;
                    default: state_d = ST_EN_O;
                endcase
            end
            ST_EN_OI: begin
                case (deb_q)
                    2'b01:   state_d = ST_EN_I;
                    2'b10:   state_d = ST_EN_O;
                    2'b00:   state_d = ST_FAULT;
                    default: state_d = ST_EN_OI;
                endcase
            end
            ST_EN_I: begin
                case (deb_q)
                    2'b00: begin
                        state_d     = ST_IDLE;
                        car_enter_d = 1'b1;
                    end
                    2'b11:   state_d = ST_EN_OI;
                    2'b10:   state_d = ST_FAULT;
                    default: state_d = ST_EN_I;
                endcase
            end
            ST_EX_I: begin
                case (deb_q)
                    2'b11:   state_d = ST_EX_IO;
                    2'b00:   state_d = ST_IDLE;
                    2'b10:   state_d = ST_FAULT;
                    default: state_d = ST_EX_I;
                endcase
            end
            ST_EX_IO: begin
                case (deb_q)
                    2'b10:   state_d = ST_EX_O;
                    2'b01:   state_d = ST_EX_I;
                    2'b00:   state_d = ST_FAULT;
                    default: state_d = ST_EX_IO;
                endcase
            end
            ST_EX_O: begin
                case (deb_q)
                    2'b00: begin
                        state_d    = ST_IDLE;
                        car_exit_d = 1'b1;
                    end
                    2'b11:   state_d = ST_EX_IO;
                    2'b01:   state_d = ST_FAULT;
                    default: state_d = ST_EX_O;
                endcase
            end
            default: begin // ST_FAULT: wait for a clear lane held long enough
                if ((deb_q == 2'b00) && (cnt_q == c_flt_last)) state_d = ST_IDLE;
            end
        endcase

        // Watchdog only fires when the lane is otherwise idle in a
        // traversal state, so it never collides with a completion pulse.
        if (in_trav && (state_d == state_q) && (cnt_q >= c_tmo_last)) begin
            state_d = ST_FAULT;
        end

        // Shared counter: clears on every state change, counts time spent
        // in a traversal state, or clear-lane time while in FAULT.
        if (state_d == state_q) begin
            if (in_trav || ((state_q == ST_FAULT) && (deb_q == 2'b00))) begin
                cnt_d = (cnt_q == c_cnt_sat) ? cnt_q : cnt_q + c_cnt_w'(1);
            end
        end

        gate_open_d = (state_d != ST_IDLE) && (state_d != ST_FAULT);
        fault_d     = (state_d == ST_FAULT);
        full_lamp_d = (spots_free == '0);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            for (int s = 0; s < 2; s++) db_cnt_q[s] <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            car_enter_q <= 1'b0;
            car_exit_q  <= 1'b0;
            gate_open_q <= 1'b0;
            full_lamp_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            sync1_q     <= {sensor_outer, sensor_inner};
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            for (int s = 0; s < 2; s++) db_cnt_q[s] <= db_cnt_d[s];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            car_enter_q <= car_enter_d;
            car_exit_q  <= car_exit_d;
            gate_open_q <= gate_open_d;
            full_lamp_q <= full_lamp_d;
            fault_q     <= fault_d;
        end
    end

    assign car_enter = car_enter_q;
    assign car_exit  = car_exit_q;
    assign gate_open = gate_open_q;
    assign full_lamp = full_lamp_q;
    assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_gate_controller
// Description : Directed self-checking bench for parking_gate_controller
//               (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_gate_controller;

    localparam int SPOT_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              sensor_outer;
    logic              sensor_inner;
    logic [SPOT_W-1:0] spots_free;
    logic              car_enter;
    logic              car_exit;
    logic              gate_open;
    logic              full_lamp;
    logic              fault;

    int n_cmp = 0;
    int n_err = 0;

    // Pulse monitor state (written only by the monitor process)
    int cyc = 0;
    int n_enter = 0;
    int n_exit = 0;
    int last_enter_cyc = 0;
    int last_exit_cyc = 0;
    int viol = 0;
    logic prev_enter = 1'b0;
    logic prev_exit  = 1'b0;

    parking_gate_controller #(
        .SPOT_W          (SPOT_W),
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sensor_outer (sensor_outer),
        .sensor_inner (sensor_inner),
        .spots_free   (spots_free),
        .car_enter    (car_enter),
        .car_exit     (car_exit),
        .gate_open    (gate_open),
        .full_lamp    (full_lamp),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count pulses and enforce the pulse rules (never both, never 2 cycles)
    always @(posedge clk) begin
        #1;
        if (car_enter) begin
            n_enter++;
            last_enter_cyc = cyc;
        end
        if (car_exit) begin
            n_exit++;
            last_exit_cyc = cyc;
        end
        if ((car_enter && car_exit) || (car_enter && prev_enter) || (car_exit && prev_exit))
            viol++;
        prev_enter = car_enter;
        prev_exit  = car_exit;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full entry: outer, both, inner, clear; each phase 10 cycles
    task automatic do_entry(input string tag);
        int e0, x0, t0, lat;
        e0 = n_enter;
        x0 = n_exit;
        sensor_outer = 1'b1; tick(10);
        chk({tag, "_gate_o"}, gate_open, 1);
        sensor_inner = 1'b1; tick(10);
        chk({tag, "_gate_oi"}, gate_open, 1);
        sensor_outer = 1'b0; tick(10);
        chk({tag, "_gate_i"}, gate_open, 1);
        chk({tag, "_no_early_pulse"}, n_enter - e0, 0);
        sensor_inner = 1'b0; t0 = cyc; tick(10);
        lat = last_enter_cyc - t0;
        chk({tag, "_gate_closed"}, gate_open, 0);
        chk({tag, "_enter_pulses"}, n_enter - e0, 1);
        chk({tag, "_no_exit"}, n_exit - x0, 0);
        chk({tag, "_latency_6to7"}, (lat == 6 || lat == 7), 1);
    endtask

    // Full exit: inner, both, outer, clear
    task automatic do_exit(input string tag);
        int e0, x0, t0, lat;
        e0 = n_enter;
        x0 = n_exit;
        sensor_inner = 1'b1; tick(10);
        chk({tag, "_gate_i"}, gate_open, 1);
        sensor_outer = 1'b1; tick(10);
        sensor_inner = 1'b0; tick(10);
        chk({tag, "_gate_o"}, gate_open, 1);
        sensor_outer = 1'b0; t0 = cyc; tick(10);
        lat = last_exit_cyc - t0;
        chk({tag, "_gate_closed"}, gate_open, 0);
        chk({tag, "_exit_pulses"}, n_exit - x0, 1);
        chk({tag, "_no_enter"}, n_enter - e0, 0);
        chk({tag, "_latency_6to7"}, (lat == 6 || lat == 7), 1);
    endtask

    initial begin
        int e0, x0;
        logic seen_gate;

        reset        = 1'b1;
        sensor_outer = 1'b0;
        sensor_inner = 1'b0;
        spots_free   = 8'd8;
        tick(3);
        chk("rst_car_enter", car_enter, 0);
        chk("rst_car_exit",  car_exit,  0);
        chk("rst_gate",      gate_open, 0);
        chk("rst_fault",     fault,     0);
        chk("rst_full",      full_lamp, 0);
        reset = 1'b0;
        tick(2);

        do_entry("entry");
        do_exit("exit");

        // Full lot: entry refused, exit still allowed
        spots_free = 8'd0;
        tick(2);
        chk("full_lamp_on", full_lamp, 1);
        e0 = n_enter;
        sensor_outer = 1'b1; tick(10);
        chk("full_gate_shut", gate_open, 0);
        chk("full_no_fault", fault, 0);
        sensor_outer = 1'b0; tick(10);
        chk("full_no_enter", n_enter - e0, 0);
        do_exit("full_exit");
        spots_free = 8'd8;
        tick(2);
        chk("full_lamp_off", full_lamp, 0);

        // Back-out: outer only, then clear
        e0 = n_enter; x0 = n_exit;
        sensor_outer = 1'b1; tick(10);
        chk("backout_gate_up", gate_open, 1);
        sensor_outer = 1'b0; tick(10);
        chk("backout_gate_down", gate_open, 0);
        chk("backout_no_pulse", (n_enter - e0) + (n_exit - x0), 0);

        // 3-cycle glitch on outer must be filtered
        seen_gate = 1'b0;
        sensor_outer = 1'b1; tick(3);
        sensor_outer = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            seen_gate = seen_gate | gate_open;
        end
        chk("glitch_ignored", seen_gate, 0);

        // Timeout: EN_O held for exactly 64 cycles, then FAULT
        e0 = n_enter;
        sensor_outer = 1'b1; tick(70);
        chk("tmo_before_fault", fault, 0);
        chk("tmo_before_gate", gate_open, 1);
        tick(1);
        chk("tmo_fault_set", fault, 1);
        chk("tmo_gate_drop", gate_open, 0);
        tick(29);
        chk("tmo_fault_held", fault, 1);
        sensor_outer = 1'b0; tick(12);
        chk("tmo_fault_clear", fault, 0);
        chk("tmo_idle_gate", gate_open, 0);
        chk("tmo_no_pulse", n_enter - e0, 0);

        // Async reset while in EN_OI
        e0 = n_enter;
        sensor_outer = 1'b1; tick(10);
        sensor_inner = 1'b1; tick(10);
        chk("ar_gate_before", gate_open, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_gate_immediate", gate_open, 0);
        chk("ar_fault_immediate", fault, 0);
        sensor_outer = 1'b0;
        sensor_inner = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(12);
        chk("ar_no_pulse", n_enter - e0, 0);
        chk("ar_still_idle", gate_open, 0);
        do_entry("after_reset");

        chk("pulse_rules", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
